// File: rtl/pwm_gpio_pkg.sv
// Shared helpers for the pwm_gpio block: counter width derivation used by the
// top-level PWM core and the per-input debouncers.
package pwm_gpio_pkg;

   // Width needed to hold 0..n-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One input lane: two-flop synchroniser, hold-time debounce counter, accepted
// level and a sticky rising-edge flag.
module btn_debounce
   import pwm_gpio_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 65536,
   localparam int unsigned DBW = cnt_width(DB_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   input  logic clr_rise,
   output logic btn_o,
   output logic btn_rise
);

   logic           sync1_q, sync2_q;
   logic [DBW-1:0] cnt_q, cnt_d;
   logic           level_q, level_d;
   logic           rise_q, rise_d;
   logic           set_rise;

   always_comb begin
      cnt_d    = '0;
      level_d  = level_q;
      set_rise = 1'b0;
      // Counter only runs while the synchronised input disagrees with the
      // accepted level; any bounce back restarts the hold time.
      if (sync2_q != level_q) begin
         if (cnt_q == DBW'(DB_CYCLES - 1)) begin
            level_d  = sync2_q;
            set_rise = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // Set has priority over a coincident clear so no edge is lost.
      rise_d = set_rise | (rise_q & ~clr_rise);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign btn_o    = level_q;
   assign btn_rise = rise_q;

endmodule

// File: rtl/pwm_gpio.sv
// General-purpose I/O block: CHANNELS double-buffered PWM outputs with
// period-aligned duty updates, plus INPUTS debounced inputs with edge flags.
module pwm_gpio
   import pwm_gpio_pkg::*;
#(
   parameter int unsigned CHANNELS  = 12,
   parameter int unsigned PWM_BITS  = 8,
   parameter int unsigned PRESCALE  = 96,
   parameter int unsigned INPUTS    = 4,
   parameter int unsigned DB_CYCLES = 65536,
   localparam int unsigned AW  = cnt_width(CHANNELS),
   localparam int unsigned PSW = cnt_width(PRESCALE)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [AW-1:0]       addr,
   input  logic [PWM_BITS-1:0] wdata,
   output logic [CHANNELS-1:0] pwm_o,
   input  logic [INPUTS-1:0]   btn_i,
   output logic [INPUTS-1:0]   btn_o,
   output logic [INPUTS-1:0]   btn_rise,
   input  logic [INPUTS-1:0]   clr_rise
);

   logic [PSW-1:0]      psc_q, psc_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic                tick, wrap, addr_ok;

   logic [PWM_BITS-1:0] shadow_q [CHANNELS];
   logic [PWM_BITS-1:0] shadow_d [CHANNELS];
   logic [PWM_BITS-1:0] active_q [CHANNELS];
   logic [PWM_BITS-1:0] active_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_q, pwm_d;

   // With PRESCALE == 1 the prescaler is pinned at zero and tick is constant.
   assign tick    = (psc_q == PSW'(PRESCALE - 1));
   assign wrap    = tick & (&cnt_q);
   assign addr_ok = (32'(addr) < CHANNELS);

   always_comb begin
      psc_d = tick ? '0 : psc_q + 1'b1;
      cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         shadow_d[i] = (wr_en && addr_ok && (addr == AW'(i))) ? wdata : shadow_q[i];
         // Loading from shadow_d gives the write-on-wrap bypass for free.
         active_d[i] = wrap ? shadow_d[i] : active_q[i];
         pwm_d[i]    = (cnt_q < active_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q <= '0;
         cnt_q <= '0;
         pwm_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         psc_q <= psc_d;
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   assign pwm_o = pwm_q;

   for (genvar k = 0; k < INPUTS; k++) begin : g_btn
      btn_debounce #(
         .DB_CYCLES(DB_CYCLES)
      ) u_db (
         .clk      (clk),
         .rst_n    (rst_n),
         .btn_i    (btn_i[k]),
         .clr_rise (clr_rise[k]),
         .btn_o    (btn_o[k]),
         .btn_rise (btn_rise[k])
      );
   end

endmodule

// File: tb/tb_pwm_gpio.sv
// Directed bench for pwm_gpio: per-period PWM waveform scoreboard plus
// debounce, edge-flag and asynchronous reset checks.
module tb_pwm_gpio;

   localparam int unsigned CH  = 3;
   localparam int unsigned PB  = 4;
   localparam int unsigned PER = 32;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic [1:0]    addr;
   logic [PB-1:0] wdata;
   logic [CH-1:0] pwm_o;
   logic [1:0]    btn_i;
   logic [1:0]    btn_o;
   logic [1:0]    btn_rise;
   logic [1:0]    clr_rise;

   pwm_gpio #(
      .CHANNELS  (CH),
      .PWM_BITS  (PB),
      .PRESCALE  (2),
      .INPUTS    (2),
      .DB_CYCLES (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .addr     (addr),
      .wdata    (wdata),
      .pwm_o    (pwm_o),
      .btn_i    (btn_i),
      .btn_o    (btn_o),
      .btn_rise (btn_rise),
      .clr_rise (clr_rise)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors;
   int          miscompares;
   int          n;
   bit          win_en;
   int          m_shadow [CH];
   int          m_active [CH];
   logic [31:0] obs_pat  [CH];
   logic [31:0] exp_q    [$];

   // Expected waveform of one period: high for the first 2*d clk (PRESCALE=2).
   function automatic logic [31:0] pat(input int d);
      logic [31:0] p;
      for (int j = 0; j < 32; j++) p[j] = ((j / 2) < d);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clk: update the reference duty model, record the PWM sample and
   // score a full period at every wrap.
   task automatic step();
      logic [31:0] e;
      @(posedge clk);
      n++;
      for (int c = 0; c < CH; c++)
         if (wr_en && addr == 2'(c)) m_shadow[c] = int'(wdata);
      #1;
      if (win_en) begin
         for (int c = 0; c < CH; c++) obs_pat[c][(n - 1) % PER] = pwm_o[c];
         if (n % PER == 0) begin
            for (int c = 0; c < CH; c++) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("sb_empty_ch%0d_n%0d", c, n), 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("period_ch%0d_n%0d", c, n), obs_pat[c], e);
               end
            end
            for (int c = 0; c < CH; c++) begin
               m_active[c] = m_shadow[c];
               exp_q.push_back(pat(m_active[c]));
            end
         end
      end
   endtask

   task automatic step_to(input int r);
      while (n % PER != r) step();
   endtask

   task automatic wr(input logic [1:0] a, input logic [PB-1:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      n           = 0;
      win_en      = 1'b0;
      rst_n       = 1'b0;
      wr_en       = 1'b0;
      addr        = '0;
      wdata       = '0;
      btn_i       = '0;
      clr_rise    = '0;
      for (int c = 0; c < CH; c++) begin
         m_shadow[c] = 0;
         m_active[c] = 0;
         obs_pat[c]  = '0;
      end

      // Reset state, then idle periods with no writes.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pwm", 32'(pwm_o), 32'd0);
      chk("reset_btn_o", 32'(btn_o), 32'd0);
      chk("reset_rise", 32'(btn_rise), 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < CH; c++) exp_q.push_back(pat(0));
      win_en = 1'b1;
      repeat (128) step();

      // Initial duties written mid-period.
      step_to(5);
      wr(2'd0, 4'd4);
      wr(2'd1, 4'd15);
      wr(2'd2, 4'd0);
      step_to(0);
      step_to(10);

      // Mid-period rewrite, then a write sampled exactly on the wrap edge.
      wr(2'd0, 4'd12);
      step_to(0);
      step_to(31);
      wr(2'd2, 4'd5);

      // Out-of-range channel write must be ignored.
      step_to(10);
      wr(2'd3, 4'd7);
      step_to(0);
      repeat (PER) step();

      // Glitch shorter than the debounce time.
      btn_i[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) btn_i[0] = 1'b0;
         step();
         chk($sformatf("glitch_btn_o_%0d", i), 32'(btn_o[0]), 32'd0);
         chk($sformatf("glitch_rise_%0d", i), 32'(btn_rise[0]), 32'd0);
      end

      // Stable press: level after 2 + DB_CYCLES clk, sticky flag until cleared.
      btn_i[0] = 1'b1;
      repeat (9) step();
      chk("press0_early", 32'(btn_o[0]), 32'd0);
      step();
      chk("press0_level", 32'(btn_o[0]), 32'd1);
      chk("press0_rise", 32'(btn_rise[0]), 32'd1);
      repeat (10) step();
      chk("press0_rise_held", 32'(btn_rise[0]), 32'd1);
      clr_rise[0] = 1'b1;
      step();
      clr_rise[0] = 1'b0;
      chk("clr0_rise", 32'(btn_rise[0]), 32'd0);
      chk("clr0_level", 32'(btn_o[0]), 32'd1);

      // Clear coincident with the set: set wins. Release leaves flag alone.
      btn_i[1] = 1'b1;
      repeat (9) step();
      clr_rise[1] = 1'b1;
      step();
      clr_rise[1] = 1'b0;
      chk("press1_level", 32'(btn_o[1]), 32'd1);
      chk("press1_set_wins", 32'(btn_rise[1]), 32'd1);
      btn_i[1] = 1'b0;
      repeat (9) step();
      chk("release1_early", 32'(btn_o[1]), 32'd1);
      step();
      chk("release1_level", 32'(btn_o[1]), 32'd0);
      chk("release1_rise", 32'(btn_rise[1]), 32'd1);
      chk("rise0_untouched", 32'(btn_rise[0]), 32'd0);

      // Asynchronous reset mid-period while outputs are active.
      step_to(12);
      chk("pre_reset_pwm1", 32'(pwm_o[1]), 32'd1);
      chk("pre_reset_btn_o", 32'(btn_o), 32'd1);
      chk("pre_reset_rise", 32'(btn_rise), 32'd2);
      win_en = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_pwm", 32'(pwm_o), 32'd0);
      chk("async_reset_btn_o", 32'(btn_o), 32'd0);
      chk("async_reset_rise", 32'(btn_rise), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) step();
      chk("post_reset_pwm", 32'(pwm_o), 32'd0);
      chk("post_reset_btn_o", 32'(btn_o), 32'd1);
      chk("post_reset_rise", 32'(btn_rise), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
